hpdcache_cmo_arbiter: RTL and testbench

Shares the single CMO handler among NREQ requesters (core ports, prefetcher, debug) under round-robin priority. It latches the granted request, issues it to the handler, and watches the handler's ready to detect completion. It then returns a one-cycle completion pulse to the originating requester. It sits between the requester ports and the CMO handler request interface, and holds at most one CMO in flight.

---
 rtl/hpdcache_pkg.sv | 30 +++
 rtl/hpdcache_rrarb.sv | 44 ++++
 rtl/hpdcache_cmo_arbiter.sv | 104 ++++++++++
 tb/tb_hpdcache_cmo_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types for the CMO path: handler op encoding, request field types
// and the CMO arbiter state encoding.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_PA_WIDTH       = 40;
  localparam int unsigned HPDCACHE_REQ_DATA_WIDTH = 64;

  typedef logic [HPDCACHE_PA_WIDTH-1:0]       hpdcache_req_addr_t;
  typedef logic [HPDCACHE_REQ_DATA_WIDTH-1:0] hpdcache_req_data_t;

  // Exactly one bit may be set for a request the handler can execute
  typedef struct packed {
    logic is_inval_all;
    logic is_inval_by_set;
    logic is_inval_by_nline;
    logic is_fence;
  } hpdcache_cmoh_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DRAIN = 2'd3
  } hpdcache_cmo_arb_fsm_t;

  function automatic logic cmo_op_is_valid(input hpdcache_cmoh_op_t op);
    return $onehot({op.is_inval_all, op.is_inval_by_set, op.is_inval_by_nline, op.is_fence});
  endfunction

endpackage

// File: rtl/hpdcache_rrarb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer, which
// moves past the winner only when the grant is actually taken (en_i).
module hpdcache_rrarb #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_any_o
);

  logic [PW-1:0] ptr_q;
  logic [PW:0]   cand;

  // Explicit wrap keeps the search in range for non-power-of-2 N
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!gnt_any_o && req_i[cand[PW-1:0]]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = cand[PW-1:0];
      end
    end
    if (gnt_any_o) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (en_i && gnt_any_o) begin
      ptr_q <= (gnt_idx_o == PW'(N-1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/hpdcache_cmo_arbiter.sv
// Shares the single CMO handler among NREQ requesters: round-robin grant, latch,
// issue, wait for the handler to return to ready, then pulse the originator.
module hpdcache_cmo_arbiter
  import hpdcache_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic               [NREQ-1:0]        req_valid_i,
  output logic               [NREQ-1:0]        req_ready_o,
  input  hpdcache_cmoh_op_t  [NREQ-1:0]        req_op_i,
  input  hpdcache_req_addr_t [NREQ-1:0]        req_addr_i,
  input  hpdcache_req_data_t [NREQ-1:0]        req_wdata_i,
  output logic               [NREQ-1:0]        rsp_valid_o,
  output logic                                 rsp_error_o,
  output logic                                 busy_o,
  output logic                                 cmoh_req_valid_o,
  input  logic                                 cmoh_req_ready_i,
  output hpdcache_cmoh_op_t                    cmoh_req_op_o,
  output hpdcache_req_addr_t                   cmoh_req_addr_o,
  output hpdcache_req_data_t                   cmoh_req_wdata_o
);

  // state      | meaning
  // ARB_IDLE   | no CMO in flight, grant the next valid requester
  // ARB_ISSUE  | latched request presented to the handler
  // ARB_WAIT   | handler accepted, waiting for it to become ready again
  // ARB_DRAIN  | malformed op, error completion without touching the handler

  hpdcache_cmo_arb_fsm_t state_q;
  hpdcache_cmoh_op_t     op_q;
  hpdcache_req_addr_t    addr_q;
  hpdcache_req_data_t    wdata_q;
  logic [IDW-1:0]        id_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            idle;

  assign idle = (state_q == ARB_IDLE);

  hpdcache_rrarb #(
    .N  (NREQ),
    .PW (IDW)
  ) rrarb_i (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .en_i      (idle),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign req_ready_o = idle ? gnt : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE:  if (gnt_any) state_q <= cmo_op_is_valid(req_op_i[gnt_idx]) ? ARB_ISSUE : ARB_DRAIN;
        ARB_ISSUE: if (cmoh_req_ready_i) state_q <= ARB_WAIT;
        ARB_WAIT:  if (cmoh_req_ready_i) state_q <= ARB_IDLE;
        ARB_DRAIN: state_q <= ARB_IDLE;
        default:   state_q <= ARB_IDLE;
      endcase
    end
  end

  // Payload is only ever captured in IDLE, so it cannot move while the handler stalls
  always_ff @(posedge clk_i) begin
    if (idle && gnt_any) begin
      op_q    <= req_op_i[gnt_idx];
      addr_q  <= req_addr_i[gnt_idx];
      wdata_q <= req_wdata_i[gnt_idx];
      id_q    <= gnt_idx;
    end
  end

  assign cmoh_req_valid_o = (state_q == ARB_ISSUE);
  assign cmoh_req_op_o    = op_q;
  assign cmoh_req_addr_o  = addr_q;
  assign cmoh_req_wdata_o = wdata_q;
  assign busy_o           = !idle;
  assign rsp_error_o      = (state_q == ARB_DRAIN);

  always_comb begin
    rsp_valid_o = '0;
    if ((state_q == ARB_WAIT && cmoh_req_ready_i) || state_q == ARB_DRAIN) rsp_valid_o[id_q] = 1'b1;
  end

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
  a_rsp_onehot0:   assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rsp_valid_o));
  a_valid_issue:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    cmoh_req_valid_o |-> state_q == ARB_ISSUE);
  a_fields_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    cmoh_req_valid_o && !cmoh_req_ready_i |=>
                                    $stable(op_q) && $stable(addr_q) && $stable(wdata_q));

endmodule

// File: tb/tb_hpdcache_cmo_arbiter.sv
// Directed bench for hpdcache_cmo_arbiter with hand-computed expectations.
module tb_hpdcache_cmo_arbiter;
  import hpdcache_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam logic [3:0] OP_FENCE = 4'b0001;
  localparam logic [3:0] OP_NLINE = 4'b0010;
  localparam logic [3:0] OP_SET   = 4'b0100;
  localparam logic [3:0] OP_ALL   = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            rst_n;
  logic               [NREQ-1:0]   req_valid;
  logic               [NREQ-1:0]   req_ready;
  hpdcache_cmoh_op_t  [NREQ-1:0]   req_op;
  hpdcache_req_addr_t [NREQ-1:0]   req_addr;
  hpdcache_req_data_t [NREQ-1:0]   req_wdata;
  logic               [NREQ-1:0]   rsp_valid;
  logic                            rsp_error;
  logic                            busy;
  logic                            cmoh_valid;
  logic                            cmoh_ready;
  hpdcache_cmoh_op_t               cmoh_op;
  hpdcache_req_addr_t              cmoh_addr;
  hpdcache_req_data_t              cmoh_wdata;

  int checks = 0;
  int errors = 0;

  hpdcache_cmo_arbiter #(.NREQ(NREQ)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_i         (req_op),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .rsp_valid_o      (rsp_valid),
    .rsp_error_o      (rsp_error),
    .busy_o           (busy),
    .cmoh_req_valid_o (cmoh_valid),
    .cmoh_req_ready_i (cmoh_ready),
    .cmoh_req_op_o    (cmoh_op),
    .cmoh_req_addr_o  (cmoh_addr),
    .cmoh_req_wdata_o (cmoh_wdata)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input hpdcache_req_addr_t obs, input hpdcache_req_addr_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input hpdcache_req_data_t obs, input hpdcache_req_data_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk4({tag, "_ready"}, req_ready, 4'b0000);
    chk4({tag, "_rsp"}, rsp_valid, 4'b0000);
    chk1({tag, "_err"}, rsp_error, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_cvalid"}, cmoh_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    rst_n      = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    cmoh_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_quiet("rst");
    tick();
    tick();
    rst_n = 1'b1;
    #1 chk_quiet("post_rst");

    // 1: single fence from requester 2, handler always ready
    req_valid = 4'b0100;
    req_op[2] = OP_FENCE;
    req_addr[2] = 40'h00_0000_1000;
    #1;
    chk4("t1_grant", req_ready, 4'b0100);
    chk1("t1_busy_T", busy, 1'b0);
    tick();
    req_valid = '0;
    #1;
    chk1("t1_cvalid", cmoh_valid, 1'b1);
    chk4("t1_cop", cmoh_op, OP_FENCE);
    chk4("t1_noready", req_ready, 4'b0000);
    chk1("t1_busy_T1", busy, 1'b1);
    tick();
    chk4("t1_rsp", rsp_valid, 4'b0100);
    chk1("t1_err", rsp_error, 1'b0);
    chk1("t1_cvalid_wait", cmoh_valid, 1'b0);
    tick();
    chk1("t1_busy_T3", busy, 1'b0);
    chk4("t1_rsp_gone", rsp_valid, 4'b0000);

    // 2: all requesters valid, pointer 0, handler busy 3 cycles per op
    do_reset();
    for (int r = 0; r < 4; r++) req_op[r] = OP_SET;
    for (int k = 0; k < 5; k++) begin
      req_valid  = 4'hF;
      cmoh_ready = 1'b1;
      #1 chk4($sformatf("t2_grant%0d", k), req_ready, 4'(1 << exp_order[k]));
      tick();
      chk1($sformatf("t2_cvalid%0d", k), cmoh_valid, 1'b1);
      chk4($sformatf("t2_issue_noready%0d", k), req_ready, 4'b0000);
      tick();
      cmoh_ready = 1'b0;
      for (int w = 0; w < 3; w++) begin
        #1;
        chk4($sformatf("t2_wait_rsp%0d_%0d", k, w), rsp_valid, 4'b0000);
        chk4($sformatf("t2_wait_ready%0d_%0d", k, w), req_ready, 4'b0000);
        tick();
      end
      cmoh_ready = 1'b1;
      #1 chk4($sformatf("t2_rsp%0d", k), rsp_valid, 4'(1 << exp_order[k]));
      tick();
    end
    req_valid = '0;

    // 3: inval_all on requester 1, handler busy 128 cycles, others keep requesting
    req_valid   = 4'b0010;
    req_op[1]   = OP_ALL;
    req_addr[1] = 40'h00_00AB_C000;
    req_wdata[1] = 64'h0000_0000_0000_000F;
    #1 chk4("t3_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1101;
    req_op[0] = OP_FENCE;
    req_op[2] = OP_FENCE;
    req_op[3] = OP_FENCE;
    req_addr[1] = 40'h00_FFFF_FFC0;
    #1;
    chk1("t3_cvalid", cmoh_valid, 1'b1);
    chk4("t3_cop", cmoh_op, OP_ALL);
    tick();
    cmoh_ready = 1'b0;
    for (int w = 0; w < 128; w++) begin
      #1;
      chk4("t3_wait_ready", req_ready, 4'b0000);
      chk4("t3_wait_rsp", rsp_valid, 4'b0000);
      chk1("t3_wait_busy", busy, 1'b1);
      chka("t3_wait_addr", cmoh_addr, 40'h00_00AB_C000);
      tick();
    end
    cmoh_ready = 1'b1;
    #1 chk4("t3_rsp", rsp_valid, 4'b0010);
    tick();
    chk4("t3_next_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    chk4("t3_next_rsp", rsp_valid, 4'b0100);
    tick();

    // 4: handler stalls ISSUE for 5 cycles, requester 3
    req_valid    = 4'b1000;
    req_op[3]    = OP_NLINE;
    req_addr[3]  = 40'h00_1234_5640;
    req_wdata[3] = 64'h0000_0000_0000_0003;
    #1 chk4("t4_grant", req_ready, 4'b1000);
    tick();
    req_valid    = '0;
    req_op[3]    = OP_ALL;
    req_addr[3]  = 40'h00_DEAD_BEC0;
    req_wdata[3] = 64'h0000_0000_0000_00FF;
    cmoh_ready   = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk1("t4_hold_valid", cmoh_valid, 1'b1);
      chk4("t4_hold_op", cmoh_op, OP_NLINE);
      chka("t4_hold_addr", cmoh_addr, 40'h00_1234_5640);
      chkd("t4_hold_wdata", cmoh_wdata, 64'h0000_0000_0000_0003);
      tick();
    end
    cmoh_ready = 1'b1;
    #1 chk1("t4_accept_valid", cmoh_valid, 1'b1);
    tick();
    chk1("t4_wait_novalid", cmoh_valid, 1'b0);
    chk4("t4_rsp", rsp_valid, 4'b1000);
    tick();

    // 5: malformed ops on requesters 1 and 3
    req_valid = 4'b1010;
    req_op[1] = 4'b0000;
    req_op[3] = 4'b0110;
    #1 chk4("t5_grant1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    #1;
    chk4("t5_rsp1", rsp_valid, 4'b0010);
    chk1("t5_err1", rsp_error, 1'b1);
    chk1("t5_cvalid1", cmoh_valid, 1'b0);
    chk1("t5_busy1", busy, 1'b1);
    tick();
    chk4("t5_grant3", req_ready, 4'b1000);
    chk1("t5_cvalid_idle", cmoh_valid, 1'b0);
    tick();
    req_valid = '0;
    #1;
    chk4("t5_rsp3", rsp_valid, 4'b1000);
    chk1("t5_err3", rsp_error, 1'b1);
    chk1("t5_cvalid3", cmoh_valid, 1'b0);
    tick();
    chk1("t5_idle", busy, 1'b0);

    // 6: reset in WAIT, then in ISSUE
    req_valid = 4'b0010;
    req_op[1] = OP_FENCE;
    req_op[2] = OP_FENCE;
    req_op[0] = OP_FENCE;
    req_op[3] = OP_FENCE;
    #1 chk4("t6_grant1", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    cmoh_ready = 1'b0;
    #1 chk1("t6_wait_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1 chk_quiet("t6_rst_wait");
    tick();
    cmoh_ready = 1'b1;
    #1 chk_quiet("t6_rst_wait_hold");
    rst_n = 1'b1;
    req_valid = 4'b0100;
    #1 chk4("t6_grant2", req_ready, 4'b0100);
    tick();
    req_valid  = '0;
    cmoh_ready = 1'b0;
    #1 chk1("t6_issue_valid", cmoh_valid, 1'b1);
    rst_n = 1'b0;
    #1 chk_quiet("t6_rst_issue");
    tick();
    rst_n = 1'b1;
    cmoh_ready = 1'b1;
    #1 chk_quiet("t6_post_rst");
    req_valid = 4'b1001;
    #1 chk4("t6_ptr0_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1 chk4("t6_no_stale_rsp", rsp_valid, 4'b0000);
    tick();
    chk4("t6_rsp0", rsp_valid, 4'b0001);
    chk1("t6_err0", rsp_error, 1'b0);
    tick();
    chk_quiet("t6_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
